// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the left-turn traffic-light system: the 2-bit light
// encoding driven by the controller on La/Lb, and the lane indices used by
// the road-side sensor model when it keeps its four lanes in arrays.
// ---------------------------------------------------------------------------
package tl_pkg;

  // Light encoding; all four codes are legal.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] LEFT   = 2'b11;

  // Lane ordering inside the sensor's per-lane arrays.
  localparam int NUM_LANES = 4;
  localparam int LANE_A    = 0;  // street A straight
  localparam int LANE_AL   = 1;  // street A left turn
  localparam int LANE_B    = 2;  // street B straight
  localparam int LANE_BL   = 3;  // street B left turn

endpackage

// File: rtl/tl_lane_q.sv
// ---------------------------------------------------------------------------
// tl_lane_q
// One traffic lane: a saturating queue counter plus a departure pacing timer.
// While enabled and non-empty, one vehicle leaves every DEPART_CYC edges;
// disabling the lane or emptying it restarts the pacing from zero.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   arr      in   one vehicle arrives this cycle (level sampled)
//   en       in   lane has right-of-way
//   q        out  registered queue depth
//   occ      out  registered "queue non-empty", from the next-state count
//   drop     out  combinational: an arrival is being lost at a full queue
// ---------------------------------------------------------------------------
module tl_lane_q #(
  parameter int CNT_W      = 4,
  parameter int DEPART_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic             occ,
  output logic             drop
);

  // A DEPART_CYC of 1 needs no real timer, but keep one bit so widths stay legal.
  localparam int TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(DEPART_CYC - 1);
  localparam logic [CNT_W-1:0] Q_MAX  = '1;

  logic [CNT_W-1:0] count_reg, count_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             occ_reg;
  logic             active;
  logic             depart;

  always_comb begin
    active     = en && (count_reg != '0);
    depart     = active && (timer_reg == T_LAST);
    timer_next = '0;
    if (active && !depart) begin
      timer_next = timer_reg + 1'b1;
    end

    count_next = count_reg;
    drop       = 1'b0;
    if (arr && !depart) begin
      if (count_reg == Q_MAX) begin
        drop = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (!arr && depart) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      timer_reg <= '0;
      occ_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      timer_reg <= timer_next;
      // Occupancy tracks the new count so it changes on the same edge as q.
      occ_reg   <= (count_next != '0);
    end
  end

  assign q   = count_reg;
  assign occ = occ_reg;

endmodule

// File: rtl/tl_traffic_sensor.sv
// ---------------------------------------------------------------------------
// tl_traffic_sensor
// Road-side model for the left-turn traffic-light controller. Queues vehicles
// in four lanes (A straight, A left, B straight, B left), releases them at a
// fixed rate while their light grants right-of-way, and reports lane
// occupancy back to the controller as its Ta/Tal/Tb/Tbl sensor inputs.
//
// Build option:
//   TL_SENSOR_YELLOW_EN  when defined, straight lanes also move on YELLOW and
//                        their pacing carries across GREEN->YELLOW.
//
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   arr_a/arr_al/arr_b/arr_bl    per-lane arrival, one vehicle per high cycle
//   La, Lb                       street A / B lights from the controller
//   Ta/Tal/Tb/Tbl                registered lane-occupied flags
//   q_a/q_al/q_b/q_bl            registered queue depths
//   ovf                          sticky: an arrival was dropped at a full queue
// ---------------------------------------------------------------------------
module tl_traffic_sensor
  import tl_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int DEPART_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arr_a,
  input  logic             arr_al,
  input  logic             arr_b,
  input  logic             arr_bl,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  output logic             Ta,
  output logic             Tal,
  output logic             Tb,
  output logic             Tbl,
  output logic [CNT_W-1:0] q_a,
  output logic [CNT_W-1:0] q_al,
  output logic [CNT_W-1:0] q_b,
  output logic [CNT_W-1:0] q_bl,
  output logic             ovf
);

  logic [NUM_LANES-1:0] arr_vec;
  logic [NUM_LANES-1:0] en_vec;
  logic [NUM_LANES-1:0] occ_vec;
  logic [NUM_LANES-1:0] drop_vec;
  logic [CNT_W-1:0]     q_lane [NUM_LANES];
  logic                 ovf_reg;

  always_comb begin
    arr_vec          = '0;
    arr_vec[LANE_A]  = arr_a;
    arr_vec[LANE_AL] = arr_al;
    arr_vec[LANE_B]  = arr_b;
    arr_vec[LANE_BL] = arr_bl;
  end

  // Right-of-way decode. Left lanes only ever move on LEFT.
  always_comb begin
    en_vec          = '0;
`ifdef TL_SENSOR_YELLOW_EN
    en_vec[LANE_A]  = (La == GREEN) || (La == YELLOW);
    en_vec[LANE_B]  = (Lb == GREEN) || (Lb == YELLOW);
`else
    en_vec[LANE_A]  = (La == GREEN);
    en_vec[LANE_B]  = (Lb == GREEN);
`endif
    en_vec[LANE_AL] = (La == LEFT);
    en_vec[LANE_BL] = (Lb == LEFT);
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      tl_lane_q #(
        .CNT_W      (CNT_W),
        .DEPART_CYC (DEPART_CYC)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .arr     (arr_vec[gi]),
        .en      (en_vec[gi]),
        .q       (q_lane[gi]),
        .occ     (occ_vec[gi]),
        .drop    (drop_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (|drop_vec) begin
      ovf_reg <= 1'b1;
    end
  end

  assign q_a  = q_lane[LANE_A];
  assign q_al = q_lane[LANE_AL];
  assign q_b  = q_lane[LANE_B];
  assign q_bl = q_lane[LANE_BL];
  assign Ta   = occ_vec[LANE_A];
  assign Tal  = occ_vec[LANE_AL];
  assign Tb   = occ_vec[LANE_B];
  assign Tbl  = occ_vec[LANE_BL];
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_tl_traffic_sensor.sv
// ---------------------------------------------------------------------------
// tb_tl_traffic_sensor
// Directed scenarios followed by random traffic, every edge compared against
// a lane model that reasons in terms of "how long has this lane been served
// continuously": a vehicle leaves on every DEPART_CYC-th served edge.
// ---------------------------------------------------------------------------
module tb_tl_traffic_sensor;
  import tl_pkg::*;

  localparam int CNT_W      = 4;
  localparam int DEPART_CYC = 4;
  localparam int QMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             arr_a, arr_al, arr_b, arr_bl;
  logic [1:0]       La, Lb;
  logic             Ta, Tal, Tb, Tbl, ovf;
  logic [CNT_W-1:0] q_a, q_al, q_b, q_bl;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: queue depth and length of the current service run.
  int m_cnt [4];
  int m_run [4];
  bit m_ovf;

  always #5 clk = ~clk;

  tl_traffic_sensor #(.CNT_W(CNT_W), .DEPART_CYC(DEPART_CYC)) dut (
    .clk(clk), .reset_n(reset_n),
    .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
    .La(La), .Lb(Lb),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .q_a(q_a), .q_al(q_al), .q_b(q_b), .q_bl(q_bl),
    .ovf(ovf)
  );

  function automatic bit lane_go(input int lane, input logic [1:0] la, input logic [1:0] lb);
    logic [1:0] l;
    bit straight;
    l = (lane < 2) ? la : lb;
    straight = (lane == 0) || (lane == 2);
    if (!straight) return (l == LEFT);
`ifdef TL_SENSOR_YELLOW_EN
    return (l == GREEN) || (l == YELLOW);
`else
    return (l == GREEN);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_run[i] = 0;
    end
    m_ovf = 0;
  endtask

  // arr bit 3 = A straight, 2 = A left, 1 = B straight, 0 = B left
  task automatic model_edge(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb);
    bit served, dep, a;
    if (!reset_n) return;
    for (int i = 0; i < 4; i++) begin
      served   = lane_go(i, la, lb) && (m_cnt[i] > 0);
      m_run[i] = served ? m_run[i] + 1 : 0;
      dep      = served && (m_run[i] % DEPART_CYC == 0);
      a        = arr[3-i];
      if (a && !dep) begin
        if (m_cnt[i] == QMAX) m_ovf = 1;
        else m_cnt[i] = m_cnt[i] + 1;
      end else if (!a && dep) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] occ_exp;
    occ_exp = {m_cnt[0] != 0, m_cnt[1] != 0, m_cnt[2] != 0, m_cnt[3] != 0};
    check("q_a",  32'(q_a),  32'(m_cnt[0]));
    check("q_al", 32'(q_al), 32'(m_cnt[1]));
    check("q_b",  32'(q_b),  32'(m_cnt[2]));
    check("q_bl", 32'(q_bl), 32'(m_cnt[3]));
    check("occ",  32'({Ta, Tal, Tb, Tbl}), 32'(occ_exp));
    check("ovf",  32'(ovf),  32'(m_ovf));
  endtask

  // Apply inputs away from the edge, clock once, update model, compare.
  task automatic step(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb);
    {arr_a, arr_al, arr_b, arr_bl} = arr;
    La = la;
    Lb = lb;
    @(posedge clk);
    model_edge(arr, la, lb);
    #1;
    check_all();
    $display("step t=%0t arr=%b La=%0d Lb=%0d q=%0d/%0d/%0d/%0d T=%b ovf=%0d",
             $time, arr, la, lb, q_a, q_al, q_b, q_bl, {Ta, Tal, Tb, Tbl}, ovf);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    step(4'b0000, RED, RED);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] la_r, lb_r;
    logic [3:0] arr_r;

    // Reset with traffic present: everything stays at zero.
    reset_n = 1'b0;
    model_reset();
    step(4'b1111, GREEN, GREEN);
    step(4'b1111, GREEN, GREEN);
    check("rst_q_a", 32'(q_a), 32'd0);
    reset_n = 1'b1;

    // Fill A straight on RED, then drain on GREEN.
    repeat (3) step(4'b1000, RED, RED);
    check("fill_q_a", 32'(q_a), 32'd3);
    check("fill_Ta",  32'(Ta),  32'd1);
    repeat (3) step(4'b0000, GREEN, RED);
    check("drain_hold", 32'(q_a), 32'd3);
    step(4'b0000, GREEN, RED);
    check("drain_e4", 32'(q_a), 32'd2);
    repeat (8) step(4'b0000, GREEN, RED);
    check("drain_e12", 32'(q_a), 32'd0);
    check("drain_Ta",  32'(Ta),  32'd0);
    // Held GREEN while empty, then one arrival: pacing starts fresh.
    repeat (5) step(4'b0000, GREEN, RED);
    step(4'b1000, GREEN, RED);
    repeat (3) step(4'b0000, GREEN, RED);
    check("fresh_hold", 32'(q_a), 32'd1);
    step(4'b0000, GREEN, RED);
    check("fresh_dep", 32'(q_a), 32'd0);

    // Simultaneous arrival and departure in A left.
    repeat (2) step(4'b0100, RED, RED);
    repeat (8) step(4'b0100, LEFT, RED);
    check("simul_q_al", 32'(q_al), 32'd8);
    check("simul_Tal",  32'(Tal),  32'd1);

    // Light change restarts pacing (A straight, two vehicles).
    pulse_reset();
    repeat (2) step(4'b1000, RED, RED);
    repeat (3) step(4'b0000, GREEN, RED);
    step(4'b0000, YELLOW, RED);
`ifdef TL_SENSOR_YELLOW_EN
    check("yel_dep", 32'(q_a), 32'd1);
`else
    check("yel_nodep", 32'(q_a), 32'd2);
    repeat (3) step(4'b0000, GREEN, RED);
    check("regreen_hold", 32'(q_a), 32'd2);
    step(4'b0000, GREEN, RED);
    check("regreen_dep", 32'(q_a), 32'd1);
`endif

    // Saturation of B straight.
    pulse_reset();
    repeat (15) step(4'b0010, RED, RED);
    check("sat_q_b", 32'(q_b), 32'(QMAX));
    check("sat_ovf0", 32'(ovf), 32'd0);
    step(4'b0010, RED, RED);
    check("sat_ovf1", 32'(ovf), 32'd1);
    step(4'b0010, RED, RED);
    repeat (3) step(4'b0000, RED, RED);
    check("sat_sticky", 32'(ovf), 32'd1);

    // Asynchronous reset mid-cycle with q_a=5.
    pulse_reset();
    repeat (5) step(4'b1000, RED, RED);
    check("pre_async", 32'(q_a), 32'd5);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_q_a", 32'(q_a), 32'd0);
    check("async_Ta",  32'(Ta),  32'd0);
    check_all();
    step(4'b1111, GREEN, LEFT);
    reset_n = 1'b1;

    // Random traffic with occasional light changes.
    la_r = RED;
    lb_r = GREEN;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) la_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) lb_r = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) arr_r[b] = ($urandom_range(0, 2) == 0);
      step(arr_r, la_r, lb_r);
      if (n == 300) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_traffic_sensor.md
Name: tl_traffic_sensor

Overview:
- Models the road side of the left-turn traffic-light controller.
- Counts vehicles queued in four lanes: A straight, A left, B straight, B left.
- Consumes the controller's La/Lb light outputs and releases queued vehicles at a fixed rate while their lane has right-of-way.
- Drives the controller's Ta/Tal/Tb/Tbl sensor inputs (lane occupied), closing the loop for system-level simulation and FPGA demo.

Parameters:
- CNT_W, 4, width of each lane queue counter; max queue = 2^CNT_W-1
- DEPART_CYC, 4, cycles between successive departures from an enabled, non-empty lane (min 1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- arr_a  input  1  one vehicle arrives in A straight lane this cycle
- arr_al  input  1  one vehicle arrives in A left lane this cycle
- arr_b  input  1  one vehicle arrives in B straight lane this cycle
- arr_bl  input  1  one vehicle arrives in B left lane this cycle
- La  input  2  street A light from controller
- Lb  input  2  street B light from controller
- Ta  output  1  A straight queue non-empty
- Tal  output  1  A left queue non-empty
- Tb  output  1  B straight queue non-empty
- Tbl  output  1  B left queue non-empty
- q_a, q_al, q_b, q_bl  output  CNT_W each  current queue depths
- ovf  output  1  sticky: an arrival was dropped at a full queue

Behaviour:
- Light encoding (tl_pkg): GREEN=2'b00, YELLOW=2'b01, RED=2'b10, LEFT=2'b11.
- Lane enables, combinational from the current La/Lb:
  - A straight enabled when La==GREEN; A left when La==LEFT.
  - B straight enabled when Lb==GREEN; B left when Lb==LEFT.
  - YELLOW and RED enable nothing, unless the optional feature below is compiled in.
- Each lane keeps a queue count and a departure timer (0..DEPART_CYC-1).
- Per lane, per rising edge:
  - If enabled and count>0: timer increments. When the timer == DEPART_CYC-1, one departure occurs and the timer returns to 0.
  - If the lane is disabled or count==0: the timer clears to 0. A light change therefore always restarts pacing.
  - Count update: +1 on arrival only, -1 on departure only. Unchanged on both or neither.
  - Full queue (count==max) with arrival and no departure: count holds and ovf sets to 1.
  - ovf stays set until reset.
  - Empty queue: no departure is possible, so no underflow.
- Timing and reset:
  - All outputs are registered. Ta=(q_a!=0) etc. is derived from the next-state count, so Ta rises on the same edge where q_a goes 0->1.
  - First departure occurs DEPART_CYC edges after enable, given a non-empty queue.
  - reset_n low, asynchronously: all counts, timers, Ta/Tal/Tb/Tbl and ovf go to 0. Arrivals are ignored while reset_n is low.
  - Reset release mid-traffic starts from empty queues.
- Arrivals are level-sampled: a high input held for N cycles means N vehicles.
- Illegal light codes do not exist; all 4 codes are defined.

Optional Feature:
- Macro TL_SENSOR_YELLOW_EN.
- Defined: a straight lane is also enabled when its light is YELLOW ("run the amber"). Its timer continues counting across a GREEN->YELLOW transition without clearing.
- Undefined: YELLOW disables departures and the timer clears on GREEN->YELLOW.
- Left lanes are unaffected in both builds.

Decomposition:
- tl_pkg: light encoding constants GREEN/YELLOW/RED/LEFT, shared with the controller and benches.
- Sub-module tl_lane_q, instantiated 4 times. It contains one counter, one timer and the full/empty logic.
  - Ports: clk, reset_n, arr, en, q, occ, drop.
- Top level:
  - decodes La/Lb into the four enables
  - ORs the drop outputs into sticky ovf
  - applies the TL_SENSOR_YELLOW_EN condition to the straight-lane enables

Test Plan (CNT_W=4, DEPART_CYC=4):
- Reset: drive arrivals and La=GREEN with reset_n=0 -> all q=0, Ta..Tbl=0, ovf=0. Assert reset_n=0 asynchronously mid-cycle with q_a=5 -> q_a=0 immediately, without waiting for a clock edge.
- Fill/drain:
  - La=RED, arr_a high 3 cycles -> q_a=3, Ta=1.
  - Then La=GREEN -> q_a decrements on the 4th, 8th and 12th edges -> q_a=0, Ta=0.
  - Held GREEN with the queue empty -> timer stays 0.
- Simultaneous: La=LEFT, q_al=2, arr_al high continuously -> q_al stays 2 across departure edges, rises only on non-departure edges; Tal stays 1.
- Saturation: Lb=RED, arr_b high 17 cycles -> q_b=15 after 15 edges, ovf=1 on edge 16, stays 1 after arr_b low.
- Light change restarts pacing:
  - La=GREEN for 3 cycles with q_a=2, then YELLOW 1 cycle, then GREEN -> no departure until 4 edges after the second GREEN (build without the macro).
  - With TL_SENSOR_YELLOW_EN -> departure occurs on the YELLOW edge.
- Closed loop: connect to tl_cntr_w_left, arr_bl pulse 1 cycle -> Tbl=1, controller reaches Lb=LEFT, q_bl returns to 0 DEPART_CYC edges later, Tbl=0.
